// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Only one transaction is outstanding at a time. Each access goes through request, grant and response.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_write_type,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [2:0]  m_write_type,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [2:0]  m_write_type_q, m_write_type_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        fetch_wins;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        m_req_d        = m_req_q;
        m_we_d         = m_we_q;
        m_write_type_d = m_write_type_q;
        m_addr_d       = m_addr_q;
        m_wdata_d      = m_wdata_q;
        if_valid_d     = 1'b0;
        d_valid_d      = 1'b0;
        if_rdata_d     = if_rdata_q;
        d_rdata_d      = d_rdata_q;
        starve_cnt_d   = starve_cnt_q;
        fetch_wins     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // Data normally wins; fetch wins when alone or after STARVE_MAX data grants.
                    fetch_wins = if_req && (!d_req || starve_cnt_q == STARVE_LIM);
                    if (fetch_wins) begin
                        owner_d        = OWN_IF;
                        m_we_d         = 1'b0;
                        m_write_type_d = 3'b000;
                        m_addr_d       = if_addr;
                        m_wdata_d      = 32'h0;
                        starve_cnt_d   = 4'd0;
                    end else begin
                        owner_d        = OWN_D;
                        m_we_d         = d_we;
                        m_write_type_d = d_write_type;
                        m_addr_d       = d_addr;
                        m_wdata_d      = d_wdata;
                        if (if_req && starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                    m_req_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (m_gnt) begin
                    m_req_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = m_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_NONE;
            m_req_q        <= 1'b0;
            m_we_q         <= 1'b0;
            m_write_type_q <= 3'b000;
            m_addr_q       <= 32'h0;
            m_wdata_q      <= 32'h0;
            if_valid_q     <= 1'b0;
            d_valid_q      <= 1'b0;
            if_rdata_q     <= 32'h0;
            d_rdata_q      <= 32'h0;
            starve_cnt_q   <= 4'd0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            m_req_q        <= m_req_d;
            m_we_q         <= m_we_d;
            m_write_type_q <= m_write_type_d;
            m_addr_q       <= m_addr_d;
            m_wdata_q      <= m_wdata_d;
            if_valid_q     <= if_valid_d;
            d_valid_q      <= d_valid_d;
            if_rdata_q     <= if_rdata_d;
            d_rdata_q      <= d_rdata_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end

    assign m_req        = m_req_q;
    assign m_we         = m_we_q;
    assign m_write_type = m_write_type_q;
    assign m_addr       = m_addr_q;
    assign m_wdata      = m_wdata_q;
    assign if_valid     = if_valid_q;
    assign if_rdata     = if_rdata_q;
    assign d_valid      = d_valid_q;
    assign d_rdata      = d_rdata_q;
    assign owner        = owner_q;
    assign stall_if     = if_req & ~if_valid_q;
    assign stall_mem    = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory that has an adjustable grant delay.
// Every transaction that reaches memory is logged by owner, so the arbitration order can be checked.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_write_type;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [2:0]  m_write_type;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic [1:0]  owner;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] mem [0:255];
    bit          model_en = 1'b1;
    int          gnt_delay = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_rdata = 32'h0;
    bit          man_gnt = 1'b0;
    bit          man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic [1:0]  grant_log [$];
    bit          m_req_seen = 1'b0;
    logic [1:0]  exp_log [0:6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01};
    bit          stray_pulse;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_write_type(d_write_type), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_write_type(m_write_type), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory responder: grants after gnt_delay cycles of m_req and completes on the following cycle.
    initial begin
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (m_req && !m_req_seen) grant_log.push_back(owner);
            m_req_seen = m_req;
            if (model_en) begin
                m_gnt    = 1'b0;
                m_rvalid = 1'b0;
                if (pend) begin
                    m_rvalid = 1'b1;
                    m_rdata  = pend_rdata;
                    pend     = 1'b0;
                end else if (m_req) begin
                    if (gnt_delay > 0) begin
                        gnt_delay--;
                    end else begin
                        m_gnt = 1'b1;
                        pend  = 1'b1;
                        if (m_we) begin
                            mem[m_addr[9:2]] = m_wdata;
                            pend_rdata = 32'hFFFF_FFFF;
                        end else begin
                            pend_rdata = mem[m_addr[9:2]];
                        end
                    end
                end
            end else begin
                pend     = 1'b0;
                m_gnt    = man_gnt;
                m_rvalid = man_rvalid;
                m_rdata  = man_rdata;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] wt,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        d_we         = we;
        d_write_type = wt;
        d_addr       = addr;
        d_wdata      = wdata;
        d_req        = 1'b1;
    endtask

    task automatic wait_d_valid(input int budget);
        int n;
        n = 0;
        while (!d_valid && n < budget) begin
            wait_cycle();
            n++;
        end
        checkOutput("d_valid_seen", {31'b0, d_valid}, 32'd1);
    endtask

    task automatic wait_if_valid(input int budget);
        int n;
        n = 0;
        while (!if_valid && n < budget) begin
            wait_cycle();
            n++;
        end
        checkOutput("if_valid_seen", {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'h0000_0093;
        mem[8] = 32'h0000_0013;
        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_write_type = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;

        repeat (2) wait_cycle();
        checkOutput("rst_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("rst_owner", {30'b0, owner}, 32'd0);
        checkOutput("rst_m_addr", m_addr, 32'h0);
        checkOutput("rst_valids", {30'b0, if_valid, d_valid}, 32'd0);
        rst = 1'b1;
        wait_cycle();

        // Single fetch with minimum latency
        if_addr = 32'h0000_0010;
        d_write_type = 3'b111;
        if_req = 1'b1;
        #1;
        checkOutput("f_stall_if_c0", {31'b0, stall_if}, 32'd1);
        wait_cycle();
        checkOutput("f_m_req", {31'b0, m_req}, 32'd1);
        checkOutput("f_m_addr", m_addr, 32'h10);
        checkOutput("f_m_we", {31'b0, m_we}, 32'd0);
        checkOutput("f_m_wt", {29'b0, m_write_type}, 32'd0);
        checkOutput("f_owner", {30'b0, owner}, 32'd1);
        wait_cycle();
        checkOutput("f_wait_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("f_wait_stall", {31'b0, stall_if}, 32'd1);
        checkOutput("f_wait_valid", {31'b0, if_valid}, 32'd0);
        wait_cycle();
        checkOutput("f_valid_c3", {31'b0, if_valid}, 32'd1);
        checkOutput("f_rdata", if_rdata, 32'h93);
        checkOutput("f_stall_c3", {31'b0, stall_if}, 32'd0);
        wait_cycle();
        if_req = 1'b0;
        checkOutput("f_valid_pulse", {31'b0, if_valid}, 32'd0);
        checkOutput("f_owner_idle", {30'b0, owner}, 32'd0);
        checkOutput("f_rdata_held", if_rdata, 32'h93);

        // Store then load
        applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        #1;
        checkOutput("s_stall_mem", {31'b0, stall_mem}, 32'd1);
        wait_cycle();
        checkOutput("s_m_we", {31'b0, m_we}, 32'd1);
        checkOutput("s_m_wt", {29'b0, m_write_type}, 32'd2);
        checkOutput("s_m_addr", m_addr, 32'h100);
        checkOutput("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
        checkOutput("s_owner", {30'b0, owner}, 32'd2);
        wait_d_valid(20);
        checkOutput("s_d_rdata_kept", d_rdata, 32'h0);
        wait_cycle();
        d_req = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'h100, 32'h0);
        wait_cycle();
        wait_cycle();
        applyStimulus(1'b0, 3'b000, 32'h100, 32'h0);
        wait_cycle();
        checkOutput("l_m_we", {31'b0, m_we}, 32'd0);
        wait_d_valid(20);
        checkOutput("l_d_rdata", d_rdata, 32'hDEAD_BEEF);
        wait_cycle();
        d_req = 1'b0;
        wait_cycle();

        // Contention: data first, fetch in the following IDLE
        if_addr = 32'h20;
        if_req  = 1'b1;
        applyStimulus(1'b0, 3'b000, 32'h100, 32'h0);
        wait_cycle();
        checkOutput("c_owner_data", {30'b0, owner}, 32'd2);
        checkOutput("c_stall_if", {31'b0, stall_if}, 32'd1);
        wait_d_valid(20);
        checkOutput("c_stall_if_dv", {31'b0, stall_if}, 32'd1);
        checkOutput("c_d_rdata", d_rdata, 32'hDEAD_BEEF);
        wait_cycle();
        d_req = 1'b0;
        checkOutput("c_owner_idle", {30'b0, owner}, 32'd0);
        checkOutput("c_stall_if_idle", {31'b0, stall_if}, 32'd1);
        wait_cycle();
        checkOutput("c_owner_fetch", {30'b0, owner}, 32'd1);
        checkOutput("c_m_addr", m_addr, 32'h20);
        wait_if_valid(20);
        checkOutput("c_if_rdata", if_rdata, 32'h13);
        wait_cycle();
        if_req = 1'b0;
        wait_cycle();

        // Starvation: both requests held; fetch forced after four data grants
        grant_log.delete();
        if_req = 1'b1;
        applyStimulus(1'b0, 3'b000, 32'h100, 32'h0);
        n = 0;
        while (grant_log.size() < 6 && n < 200) begin
            wait_cycle();
            n++;
        end
        wait_d_valid(20);
        wait_cycle();
        d_req = 1'b0;
        wait_if_valid(20);
        wait_cycle();
        if_req = 1'b0;
        checkOutput("sv_log_size", grant_log.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < grant_log.size()) checkOutput($sformatf("sv_grant%0d", i), {30'b0, grant_log[i]}, {30'b0, exp_log[i]});
        end
        wait_cycle();

        // Backpressure: grant withheld for five cycles
        gnt_delay = 5;
        applyStimulus(1'b1, 3'b001, 32'h200, 32'h1234_5678);
        wait_cycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_m_req%0d", i), {31'b0, m_req}, 32'd1);
            checkOutput($sformatf("bp_m_addr%0d", i), m_addr, 32'h200);
            d_addr = 32'h300 + 32'(i * 4);
            wait_cycle();
        end
        d_addr = 32'h200;
        wait_d_valid(20);
        checkOutput("bp_mem_written", mem[128], 32'h1234_5678);
        checkOutput("bp_mem_not_moved", mem[192], 32'h0);
        wait_cycle();
        d_req = 1'b0;
        d_we  = 1'b0;
        wait_cycle();

        // Reset during WAIT, then a stray completion
        model_en = 1'b0;
        if_addr  = 32'h40;
        if_req   = 1'b1;
        wait_cycle();
        checkOutput("r_issue_owner", {30'b0, owner}, 32'd1);
        man_gnt = 1'b1;
        wait_cycle();
        man_gnt = 1'b0;
        checkOutput("r_wait_m_req", {31'b0, m_req}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("r_owner", {30'b0, owner}, 32'd0);
        checkOutput("r_m_addr", m_addr, 32'h0);
        checkOutput("r_if_rdata", if_rdata, 32'h0);
        checkOutput("r_d_rdata", d_rdata, 32'h0);
        if_req = 1'b0;
        wait_cycle();
        wait_cycle();
        rst = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 32'h0000_0BAD;
        wait_cycle();
        man_rvalid = 1'b0;
        stray_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (if_valid || d_valid) stray_pulse = 1'b1;
            wait_cycle();
        end
        checkOutput("r_stray_pulse", {31'b0, stray_pulse}, 32'd0);
        checkOutput("r_final_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("r_final_owner", {30'b0, owner}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
